// File: rtl/dpll_pkg.sv
// rtl/dpll_pkg.sv - shared types and helpers for the DPLL frequency-lock controller
//
// Contents:
//   dpll_state_e  loop controller states
//   midscale()    reset value of the DCO trim word for a given width
//   sat_inc()     increment that stops at a ceiling instead of wrapping

package dpll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    UPDATE  = 2'd3
  } dpll_state_e;

  function automatic logic [31:0] midscale(input int unsigned code_w);
    return 32'd1 << (code_w - 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/dpll_edge_sync.sv
// rtl/dpll_edge_sync.sv - synchroniser plus registered rising-edge pulse for an async input
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   din    in   asynchronous input (ref_in or fb_in)
//   pulse  out  one-cycle pulse per rising edge of din, SYNC_STAGES+1 cycles after it

module dpll_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/dpll_freq_lock_ctrl.sv
// rtl/dpll_freq_lock_ctrl.sv - frequency-lock loop: count fb edges per ref period, trim DCO code
//
// Ports:
//   clk        in   system clock (>2x ref_in and fb_in)
//   rst_n      in   asynchronous active-low reset
//   en         in   loop enable; low returns to IDLE and holds dco_code
//   ref_in     in   reference clock, asynchronous
//   fb_in      in   divided DCO feedback, asynchronous
//   mult_n     in   target feedback edges per reference period (sampled at window start)
//   gain_sh    in   arithmetic right shift applied to the error before it trims the code
//   dco_code   out  DCO trim word, midscale after reset
//   freq_err   out  signed mult_n - count of the last completed window
//   err_valid  out  one-cycle pulse when freq_err/dco_code update
//   locked     out  set after LOCK_WINDOWS consecutive windows with |err| <= TOL
//   code_sat   out  last update was clamped at 0 or full scale

module dpll_freq_lock_ctrl
  import dpll_pkg::*;
#(
  parameter int CODE_W       = 8,
  parameter int CNT_W        = 12,
  parameter int LOCK_WINDOWS = 4,
  parameter int TOL          = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    ref_in,
  input  logic                    fb_in,
  input  logic [CNT_W-1:0]        mult_n,
  input  logic [1:0]              gain_sh,
  output logic [CODE_W-1:0]       dco_code,
  output logic signed [CNT_W:0]   freq_err,
  output logic                    err_valid,
  output logic                    locked,
  output logic                    code_sat
);

  localparam int ERR_W = CNT_W + 1;
  localparam int SUM_W = CNT_W + 2;
  localparam int LC_W  = $clog2(LOCK_WINDOWS + 1);

  localparam logic [CODE_W-1:0] CODE_MID   = CODE_W'(midscale(CODE_W));
  localparam logic [SUM_W-1:0]  CODE_MAX_U = SUM_W'((2 ** CODE_W) - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [LC_W-1:0]   LC_MAX     = LC_W'(LOCK_WINDOWS);
  localparam logic [ERR_W-1:0]  TOL_E      = ERR_W'(TOL);

  logic ref_pulse;
  logic fb_pulse;

  dpll_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ref_in),
    .pulse (ref_pulse)
  );

  dpll_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (fb_in),
    .pulse (fb_pulse)
  );

  dpll_state_e state_q, state_d;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] n_q;
  logic [LC_W-1:0]  lock_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (ref_pulse) state_d = MEASURE;
        MEASURE: if (ref_pulse) state_d = UPDATE;
        UPDATE:  state_d = MEASURE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Error, scaled step and clamped next code for the window held in count_q/n_q.
  logic signed [ERR_W-1:0] err;
  logic signed [ERR_W-1:0] shifted;
  logic signed [ERR_W-1:0] step;
  logic [ERR_W-1:0]        err_abs;
  logic                    in_tol;
  logic [SUM_W-1:0]        code_sum;
  logic [CODE_W-1:0]       code_next;
  logic                    clamped;
  logic [CNT_W-1:0]        count_inc;
  logic [LC_W-1:0]         lc_inc;

  always_comb begin
    err     = $signed({1'b0, n_q}) - $signed({1'b0, count_q});
    shifted = err >>> gain_sh;
    // A small positive error would shift to zero and stall the loop short of
    // target; keep at least one LSB of correction in the error's direction.
    step    = shifted;
    if (err != '0 && shifted == '0) begin
      step = err[ERR_W-1] ? '1 : ERR_W'(1);
    end

    err_abs = err[ERR_W-1] ? (~err + ERR_W'(1)) : err;
    in_tol  = (err_abs <= TOL_E);

    code_sum  = {{(SUM_W-CODE_W){1'b0}}, dco_code} + {step[ERR_W-1], step};
    code_next = code_sum[CODE_W-1:0];
    clamped   = 1'b0;
    if (code_sum[SUM_W-1]) begin
      code_next = '0;
      clamped   = 1'b1;
    end else if (code_sum > CODE_MAX_U) begin
      code_next = '1;
      clamped   = 1'b1;
    end

    count_inc = CNT_W'(sat_inc({{(32-CNT_W){1'b0}}, count_q}, {{(32-CNT_W){1'b0}}, CNT_MAX}));
    lc_inc    = LC_W'(sat_inc({{(32-LC_W){1'b0}}, lock_cnt}, {{(32-LC_W){1'b0}}, LC_MAX}));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      n_q       <= '0;
      lock_cnt  <= '0;
      dco_code  <= CODE_MID;
      freq_err  <= '0;
      err_valid <= 1'b0;
      locked    <= 1'b0;
      code_sat  <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      if (!en) begin
        count_q  <= '0;
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            count_q <= '0;
          end
          ARM: begin
            if (ref_pulse) begin
              count_q <= '0;
              n_q     <= mult_n;
            end
          end
          MEASURE: begin
            // A fb edge in the same cycle as the closing ref edge still lands here,
            // so it belongs to the window being closed.
            if (fb_pulse) begin
              count_q <= count_inc;
            end
          end
          UPDATE: begin
            freq_err  <= err;
            dco_code  <= code_next;
            code_sat  <= clamped;
            err_valid <= 1'b1;
            n_q       <= mult_n;
            // The new window opened on the previous cycle's ref edge.
            count_q   <= fb_pulse ? CNT_W'(1) : '0;
            if (in_tol) begin
              lock_cnt <= lc_inc;
              locked   <= (lc_inc == LC_MAX);
            end else begin
              lock_cnt <= '0;
              locked   <= 1'b0;
            end
          end
          default: begin
            count_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dpll_freq_lock_ctrl.sv
// tb/tb_dpll_freq_lock_ctrl.sv - self-checking bench for dpll_freq_lock_ctrl

module tb_dpll_freq_lock_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               ref_in;
  logic               fb_in;
  logic [11:0]        mult_n;
  logic [1:0]         gain_sh;
  logic [7:0]         dco_code;
  logic signed [12:0] freq_err;
  logic               err_valid;
  logic               locked;
  logic               code_sat;

  always #5 clk = ~clk;

  dpll_freq_lock_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ref_in    (ref_in),
    .fb_in     (fb_in),
    .mult_n    (mult_n),
    .gain_sh   (gain_sh),
    .dco_code  (dco_code),
    .freq_err  (freq_err),
    .err_valid (err_valid),
    .locked    (locked),
    .code_sat  (code_sat)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: code, consecutive in-tolerance windows, last results.
  int m_code = 128;
  int m_lc   = 0;
  int m_err  = 0;
  int m_locked = 0;
  int m_sat  = 0;
  int cur_n  = 0;

  // Values captured on the err_valid pulse.
  int c_code, c_err, c_locked, c_sat;

  typedef struct {
    int n;
    int g;
    int nfb;
    int e_err;
    int e_code;
    int e_locked;
    int e_sat;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n feedback edges, 2 cycles high / 2 low; mult_n is scrambled mid-window.
  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin
      fb_in = 1'b1;
      tick(); tick();
      fb_in = 1'b0;
      tick(); tick();
      if (k == n / 2) mult_n = 12'($urandom);
    end
  endtask

  task automatic close_window(input int exp_upd, input bit with_fb);
    int seen;
    seen = 0;
    ref_in = 1'b1;
    if (with_fb) fb_in = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (c == 1) begin
        ref_in = 1'b0;
        fb_in  = 1'b0;
      end
      if (err_valid === 1'b1) begin
        seen     = 1;
        c_code   = int'(dco_code);
        c_err    = int'(freq_err);
        c_locked = int'(locked);
        c_sat    = int'(code_sat);
      end
    end
    chk("update_seen", seen, exp_upd);
  endtask

  task automatic model_update(input int cnt, input int n, input int g);
    int d, step;
    if (cnt > 4095) cnt = 4095;
    m_err = n - cnt;
    d = 1 << g;
    if (m_err >= 0) step = m_err / d;
    else            step = -((-m_err + d - 1) / d);
    if (m_err != 0 && step == 0) step = (m_err > 0) ? 1 : -1;
    m_code = m_code + step;
    m_sat  = 0;
    if (m_code < 0) begin
      m_code = 0;
      m_sat  = 1;
    end else if (m_code > 255) begin
      m_code = 255;
      m_sat  = 1;
    end
    if (m_err >= -1 && m_err <= 1) begin
      if (m_lc < 4) m_lc++;
    end else begin
      m_lc = 0;
    end
    m_locked = (m_lc == 4) ? 1 : 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_err"},    c_err,    m_err);
    chk({tag, "_code"},   c_code,   m_code);
    chk({tag, "_locked"}, c_locked, m_locked);
    chk({tag, "_sat"},    c_sat,    m_sat);
  endtask

  task automatic run_window(input int cnt, input int g, input int next_n, input bit coinc);
    pulses(coinc ? cnt - 1 : cnt);
    mult_n  = 12'(next_n);
    gain_sh = 2'(g);
    close_window(1, coinc);
    model_update(cnt, cur_n, g);
    cur_n = next_n;
  endtask

  initial begin
    int nv;
    int cnt;

    //          n     g  nfb   err   code lock sat
    tbl[0]  = '{100,  0, 90,    10,  138, 0, 0};
    tbl[1]  = '{100,  1, 97,     3,  139, 0, 0};
    tbl[2]  = '{100,  2, 101,   -1,  138, 0, 0};
    tbl[3]  = '{100,  0, 100,    0,  138, 0, 0};
    tbl[4]  = '{100,  3, 99,     1,  139, 0, 0};
    tbl[5]  = '{100,  0, 101,   -1,  138, 1, 0};
    tbl[6]  = '{100,  0, 103,   -3,  135, 0, 0};
    tbl[7]  = '{200,  0, 80,   120,  255, 0, 0};
    tbl[8]  = '{100,  0, 99,     1,  255, 0, 1};
    tbl[9]  = '{100,  0, 101,   -1,  254, 0, 0};
    tbl[10] = '{100,  0, 80,    20,  255, 0, 1};
    tbl[11] = '{100,  3, 101,   -1,  254, 0, 0};
    tbl[12] = '{10,   0, 300, -290,    0, 0, 1};
    tbl[13] = '{4000, 0, 5000, -95,    0, 0, 1};
    tbl[14] = '{100,  0, 100,    0,    0, 0, 0};

    rst_n = 1'b0; en = 1'b0; ref_in = 1'b1; fb_in = 1'b0;
    mult_n = 12'd100; gain_sh = 2'd0;
    repeat (3) tick();
    chk("rst_code",   int'(dco_code),  128);
    chk("rst_locked", int'(locked),    0);
    chk("rst_valid",  int'(err_valid), 0);
    chk("rst_err",    int'(freq_err),  0);
    chk("rst_sat",    int'(code_sat),  0);

    // Release while ref_in is high; with en low nothing may update.
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (err_valid === 1'b1) nv++;
      if (c == 10) ref_in = 1'b0;
    end
    chk("post_reset_no_pulse", nv, 0);
    chk("post_reset_code", int'(dco_code), 128);

    // Arm: the first ref edge only starts a window.
    en = 1'b1;
    mult_n = 12'(tbl[0].n);
    repeat (4) tick();
    close_window(0, 1'b0);
    cur_n = tbl[0].n;

    for (int i = 0; i < 15; i++) begin
      pulses(tbl[i].nfb);
      mult_n  = (i < 14) ? 12'(tbl[i+1].n) : 12'd100;
      gain_sh = 2'(tbl[i].g);
      close_window(1, 1'b0);
      chk($sformatf("tbl%0d_err", i),    c_err,    tbl[i].e_err);
      chk($sformatf("tbl%0d_code", i),   c_code,   tbl[i].e_code);
      chk($sformatf("tbl%0d_locked", i), c_locked, tbl[i].e_locked);
      chk($sformatf("tbl%0d_sat", i),    c_sat,    tbl[i].e_sat);
      model_update(tbl[i].nfb, cur_n, tbl[i].g);
      cur_n = int'(mult_n);
    end

    // fb edge coincident with the closing ref edge counts in that window.
    run_window(50, 0, 100, 1'b1);
    check_model("coinc");

    // Closed loop: feedback count roughly proportional to code, with jitter.
    for (int i = 0; i < 12; i++) begin
      cnt = (m_code * 100) / 138 + int'($urandom_range(0, 2)) - 1;
      if (cnt < 0) cnt = 0;
      run_window(cnt, int'($urandom_range(0, 3)), 100, 1'b0);
      check_model("loop");
    end
    for (int i = 0; i < 4; i++) begin
      run_window(100 + int'($urandom_range(0, 2)) - 1, int'($urandom_range(0, 3)), 100, 1'b0);
      check_model("lock");
    end
    chk("lock_reached", c_locked, 1);
    run_window(103, 0, 100, 1'b0);
    check_model("unlock");
    chk("unlock_flag", c_locked, 0);

    // Relock, then drop en mid-window.
    for (int i = 0; i < 4; i++) begin
      run_window(100, 0, 100, 1'b0);
      check_model("relock");
    end
    pulses(30);
    en = 1'b0;
    tick();
    chk("en_drop_locked", int'(locked), 0);
    chk("en_drop_code",   int'(dco_code), m_code);
    chk("en_drop_valid",  int'(err_valid), 0);
    m_lc = 0;
    m_locked = 0;
    repeat (5) tick();
    en = 1'b1;
    mult_n = 12'd100;
    repeat (3) tick();
    close_window(0, 1'b0);
    cur_n = 100;
    run_window(95, 1, 100, 1'b0);
    check_model("reen");

    // Asynchronous reset in the middle of a window.
    pulses(20);
    rst_n = 1'b0;
    #1;
    chk("arst_code",   int'(dco_code),  128);
    chk("arst_locked", int'(locked),    0);
    chk("arst_err",    int'(freq_err),  0);
    chk("arst_sat",    int'(code_sat),  0);
    chk("arst_valid",  int'(err_valid), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
